// File: rtl/counter_down_timer.sv
// Loadable, cascadable down-counter with run/hold control, an expiry pulse and optional auto-reload.
// Chain stages by feeding the lower stage's borrow (ANDed with its enable) into the upper stage's enable.
module counter_down_timer #(
  parameter int unsigned      NBITS         = 4,
  parameter logic [NBITS-1:0] MAXIMUM_VALUE = 4'h9,
  parameter bit               AUTO_RELOAD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [NBITS-1:0] counter,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    EXPIRED
  } state_t;

  localparam logic [NBITS-1:0] ONE  = NBITS'(1);
  localparam logic [NBITS-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [NBITS-1:0] counter_q, counter_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= ZERO;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      done_q    <= done_d;
    end
  end

  // Load overrides everything; within a state, stop beats start and start beats enable.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    done_d    = 1'b0;
    if (load) begin
      counter_d = (load_value > MAXIMUM_VALUE) ? MAXIMUM_VALUE : load_value;
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (counter_q != ZERO) begin
              state_d = RUN;
            end else begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = HOLD;
          end else if (enable) begin
            if (counter_q == ZERO) begin
              counter_d = MAXIMUM_VALUE;
            end else if (counter_q == ONE) begin
              counter_d = ZERO;
              done_d    = 1'b1;
              if (!AUTO_RELOAD) begin
                state_d = EXPIRED;
              end
            end else begin
              counter_d = counter_q - ONE;
            end
          end
        end
        HOLD: begin
          if (!stop && start) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          counter_d = ZERO;
          if (start) begin
            counter_d = MAXIMUM_VALUE;
            state_d   = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign counter = counter_q;
  assign borrow  = (counter_q == ZERO);
  assign done    = done_q;
  assign busy    = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed bench for counter_down_timer: stop-at-zero, auto-reload and a two-stage cascade.
module tb_counter_down_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       enable0 = 1'b0, load0 = 1'b0, start0 = 1'b0, stop0 = 1'b0;
  logic [3:0] loadValue0 = 4'd0;
  logic [3:0] counter0;
  logic       borrow0, done0, busy0;

  logic       enableA = 1'b0, loadA = 1'b0, startA = 1'b0, stopA = 1'b0;
  logic [3:0] loadValueA = 4'd0;
  logic [3:0] counterA;
  logic       borrowA, doneA, busyA;

  logic       enableU, loadU = 1'b0, startU = 1'b0, stopU = 1'b0;
  logic [3:0] loadValueU = 4'd0;
  logic [3:0] counterU;
  logic       borrowU, doneU, busyU;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign enableU = borrowA & enableA;

  counter_down_timer #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .load(load0), .load_value(loadValue0),
    .start(start0), .stop(stop0), .counter(counter0), .borrow(borrow0), .done(done0), .busy(busy0)
  );

  counter_down_timer #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .AUTO_RELOAD(1'b1)) dutA (
    .clk(clk), .reset(reset), .enable(enableA), .load(loadA), .load_value(loadValueA),
    .start(startA), .stop(stopA), .counter(counterA), .borrow(borrowA), .done(doneA), .busy(busyA)
  );

  counter_down_timer #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .AUTO_RELOAD(1'b0)) dutU (
    .clk(clk), .reset(reset), .enable(enableU), .load(loadU), .load_value(loadValueU),
    .start(startU), .stop(stopU), .counter(counterU), .borrow(borrowU), .done(doneU), .busy(busyU)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({counter0, done0, busy0, borrow0} !== {4'd0, 1'b0, 1'b0, 1'b1})
      $display("[TB] FAIL reset_state: cnt/done/busy/borrow=%0d/%b/%b/%b expected 0/0/0/1",
               counter0, done0, busy0, borrow0);
    else passed++;
    checks++;
    if ({counterA, counterU} !== 8'h00)
      $display("[TB] FAIL reset_others: counterA=%0d counterU=%0d expected 0/0", counterA, counterU);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_countdown();
    load0 = 1'b1; loadValue0 = 4'd5;
    tick();
    load0 = 1'b0;
    checks++;
    if ({counter0, busy0, borrow0} !== {4'd5, 1'b0, 1'b0})
      $display("[TB] FAIL basic_load: cnt/busy/borrow=%0d/%b/%b expected 5/0/0", counter0, busy0, borrow0);
    else passed++;
    start0 = 1'b1; enable0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if ({counter0, busy0, done0} !== {4'd5, 1'b1, 1'b0})
      $display("[TB] FAIL basic_start: cnt/busy/done=%0d/%b/%b expected 5/1/0", counter0, busy0, done0);
    else passed++;
    for (int v = 4; v >= 0; v--) begin
      tick();
      checks++;
      if ({counter0, done0, busy0} !== {4'(v), (v == 0), (v != 0)})
        $display("[TB] FAIL basic_step: cnt/done/busy=%0d/%b/%b expected %0d/%b/%b",
                 counter0, done0, busy0, v, (v == 0), (v != 0));
      else passed++;
    end
    tick();
    checks++;
    if ({counter0, done0, busy0, borrow0} !== {4'd0, 1'b0, 1'b0, 1'b1})
      $display("[TB] FAIL basic_expired: cnt/done/busy/borrow=%0d/%b/%b/%b expected 0/0/0/1",
               counter0, done0, busy0, borrow0);
    else passed++;
    enable0 = 1'b0;
  endtask

  task automatic test_saturating_load();
    logic [3:0] vals [3] = '{4'hF, 4'hA, 4'h9};
    for (int i = 0; i < 3; i++) begin
      load0 = 1'b1; loadValue0 = vals[i];
      tick();
      checks++;
      if (counter0 !== 4'd9)
        $display("[TB] FAIL sat_load: load %0d gave cnt=%0d expected 9", vals[i], counter0);
      else passed++;
    end
    load0 = 1'b0;
  endtask

  task automatic test_pause_resume();
    int donePulses = 0;
    load0 = 1'b1; loadValue0 = 4'd5;
    tick();
    load0 = 1'b0; start0 = 1'b1; enable0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    checks++;
    if (counter0 !== 4'd3)
      $display("[TB] FAIL pause_pre: cnt=%0d expected 3", counter0);
    else passed++;
    stop0 = 1'b1;
    tick();
    stop0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({counter0, busy0} !== {4'd3, 1'b1})
        $display("[TB] FAIL pause_hold: cnt/busy=%0d/%b expected 3/1", counter0, busy0);
      else passed++;
      tick();
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if ({counter0, busy0} !== {4'd3, 1'b1})
      $display("[TB] FAIL pause_resume: cnt/busy=%0d/%b expected 3/1", counter0, busy0);
    else passed++;
    for (int v = 2; v >= 0; v--) begin
      tick();
      if (done0) donePulses++;
      checks++;
      if (counter0 !== 4'(v))
        $display("[TB] FAIL pause_step: cnt=%0d expected %0d", counter0, v);
      else passed++;
    end
    tick();
    if (done0) donePulses++;
    checks++;
    if (donePulses !== 1)
      $display("[TB] FAIL pause_done_count: pulses=%0d expected 1", donePulses);
    else passed++;
    enable0 = 1'b0;
  endtask

  task automatic test_load_stop_priority();
    load0 = 1'b1; loadValue0 = 4'd6; enable0 = 1'b1;
    tick();
    load0 = 1'b0;
    checks++;
    if ({counter0, busy0} !== {4'd6, 1'b0})
      $display("[TB] FAIL idle_enable: cnt/busy=%0d/%b expected 6/0", counter0, busy0);
    else passed++;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    load0 = 1'b1; loadValue0 = 4'd3;
    tick();
    load0 = 1'b0;
    checks++;
    if ({counter0, busy0} !== {4'd3, 1'b0})
      $display("[TB] FAIL load_wins: cnt/busy=%0d/%b expected 3/0", counter0, busy0);
    else passed++;
    start0 = 1'b1;
    tick();
    stop0 = 1'b1;
    tick();
    start0 = 1'b0; stop0 = 1'b0;
    tick();
    checks++;
    if ({counter0, busy0} !== {4'd3, 1'b1})
      $display("[TB] FAIL stop_wins: cnt/busy=%0d/%b expected 3/1", counter0, busy0);
    else passed++;
    enable0 = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [3:0] seq [12] = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    loadA = 1'b1; loadValueA = 4'd2;
    tick();
    loadA = 1'b0; startA = 1'b1; enableA = 1'b1;
    tick();
    startA = 1'b0;
    checks++;
    if ({counterA, busyA} !== {4'd2, 1'b1})
      $display("[TB] FAIL auto_start: cnt/busy=%0d/%b expected 2/1", counterA, busyA);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({counterA, doneA, busyA} !== {seq[i], (seq[i] == 4'd0), 1'b1})
        $display("[TB] FAIL auto_step: cnt/done/busy=%0d/%b/%b expected %0d/%b/1",
                 counterA, doneA, busyA, seq[i], (seq[i] == 4'd0));
      else passed++;
    end
    enableA = 1'b0;
  endtask

  task automatic test_cascade();
    loadA = 1'b1; loadValueA = 4'd0;
    loadU = 1'b1; loadValueU = 4'd1;
    tick();
    loadA = 1'b0; loadU = 1'b0;
    startA = 1'b1; startU = 1'b1;
    tick();
    startU = 1'b0;
    checks++;
    if (counterU * 10 + counterA !== 10)
      $display("[TB] FAIL cascade_init: value=%0d expected 10", counterU * 10 + counterA);
    else passed++;
    enableA = 1'b1;
    tick();
    startA = 1'b0;
    checks++;
    if (counterU * 10 + counterA !== 9)
      $display("[TB] FAIL cascade_step: value=%0d expected 9", counterU * 10 + counterA);
    else passed++;
    for (int v = 8; v >= 0; v--) begin
      tick();
      checks++;
      if (counterU * 10 + counterA !== v)
        $display("[TB] FAIL cascade_step: value=%0d expected %0d", counterU * 10 + counterA, v);
      else passed++;
    end
    enableA = 1'b0;
  endtask

  task automatic test_async_reset_start_zero();
    load0 = 1'b1; loadValue0 = 4'd7;
    tick();
    load0 = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({counter0, borrow0, busy0, done0} !== {4'd0, 1'b1, 1'b0, 1'b0})
      $display("[TB] FAIL async_reset: cnt/borrow/busy/done=%0d/%b/%b/%b expected 0/1/0/0",
               counter0, borrow0, busy0, done0);
    else passed++;
    #2;
    reset = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if ({counter0, done0, busy0} !== {4'd0, 1'b1, 1'b0})
      $display("[TB] FAIL start_zero: cnt/done/busy=%0d/%b/%b expected 0/1/0", counter0, done0, busy0);
    else passed++;
    tick();
    checks++;
    if (done0 !== 1'b0)
      $display("[TB] FAIL start_zero_pulse: done=%b expected 0", done0);
    else passed++;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if ({counter0, busy0, done0} !== {4'd9, 1'b1, 1'b0})
      $display("[TB] FAIL expired_restart: cnt/busy/done=%0d/%b/%b expected 9/1/0", counter0, busy0, done0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_saturating_load();
    test_pause_resume();
    test_load_stop_priority();
    test_auto_reload();
    test_cascade();
    test_async_reset_start_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
